// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-approach intersection controller.
package traffic_pkg;

    localparam int unsigned SEC_W = 7;
    localparam int unsigned LED_W = 3;
    localparam int unsigned BCD_W = 4;

    typedef enum logic [2:0] {
        A_GREEN,
        A_YELLOW,
        ALLRED1,
        B_GREEN,
        B_YELLOW,
        ALLRED2,
        FLASH
    } state_t;

    localparam logic [LED_W-1:0] LED_RED = 3'b100;
    localparam logic [LED_W-1:0] LED_YEL = 3'b010;
    localparam logic [LED_W-1:0] LED_GRN = 3'b001;
    localparam logic [LED_W-1:0] LED_OFF = 3'b000;

    // {tens, ones} of a 0..99 seconds value
    function automatic logic [2*BCD_W-1:0] toBcd(input logic [SEC_W-1:0] v);
        return {BCD_W'(v / SEC_W'(10)), BCD_W'(v % SEC_W'(10))};
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// Control inputs and lamp/countdown outputs of the intersection controller.
interface traffic_intersection_ctrl_if;
    import traffic_pkg::*;

    logic               i_en;
    logic               i_ped_req;
    logic               i_flash;
    logic [LED_W-1:0]   o_led_a;
    logic [LED_W-1:0]   o_led_b;
    logic [SEC_W-1:0]   o_sec;
    logic [BCD_W-1:0]   o_sec_tens;
    logic [BCD_W-1:0]   o_sec_ones;
    logic               o_ped_ack;

    modport master (
        output i_en, i_ped_req, i_flash,
        input  o_led_a, o_led_b, o_sec, o_sec_tens, o_sec_ones, o_ped_ack
    );

    modport slave (
        input  i_en, i_ped_req, i_flash,
        output o_led_a, o_led_b, o_sec, o_sec_tens, o_sec_ones, o_ped_ack
    );

endinterface

// File: rtl/sec_tick_gen.sv
// 1 s prescaler: counts 0..CLK_HZ-1 while enabled, tick on the last count.
module sec_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Decoded from the count so the tick lands in the same cycle as CLK_HZ-1
    assign o_tick = i_en && (cnt == LAST);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller: phase FSM, countdown, pedestrian latch,
// night flash and registered BCD digits.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned T_GREEN  = 20,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_PEDMIN = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    traffic_intersection_ctrl_if.slave  bus
);

    state_t             state, stateNxt;
    logic [SEC_W-1:0]   sec, secNxt;
    logic               pedLatch, pedNxt;
    logic               flashPhase, phaseNxt;
    logic [LED_W-1:0]   ledA, ledB, ledANxt, ledBNxt;
    logic [BCD_W-1:0]   tens, ones;
    logic               tick, tickClr;
    logic               isGreen;

    function automatic logic [SEC_W-1:0] durOf(input state_t s);
        case (s)
            A_GREEN, B_GREEN:   return SEC_W'(T_GREEN);
            A_YELLOW, B_YELLOW: return SEC_W'(T_YELLOW);
            ALLRED1, ALLRED2:   return SEC_W'(T_ALLRED);
            default:            return '0;
        endcase
    endfunction

    function automatic state_t nextOf(input state_t s);
        case (s)
            A_GREEN:  return A_YELLOW;
            A_YELLOW: return ALLRED1;
            ALLRED1:  return B_GREEN;
            B_GREEN:  return B_YELLOW;
            B_YELLOW: return ALLRED2;
            ALLRED2:  return A_GREEN;
            default:  return ALLRED1;
        endcase
    endfunction

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (bus.i_en),
        .i_clr   (tickClr),
        .o_tick  (tick)
    );

    assign isGreen = (state == A_GREEN) || (state == B_GREEN);

    // Next state, countdown and lamps; precedence flash > ped truncate > tick
    always_comb begin
        stateNxt = state;
        secNxt   = sec;
        pedNxt   = pedLatch | bus.i_ped_req;
        phaseNxt = flashPhase;
        tickClr  = 1'b0;
        ledANxt  = LED_RED;
        ledBNxt  = LED_RED;

        if (bus.i_flash) begin
            pedNxt = 1'b0;
            if (state != FLASH) begin
                stateNxt = FLASH;
                secNxt   = '0;
                phaseNxt = 1'b1;
                tickClr  = 1'b1;
            end else if (tick) begin
                phaseNxt = ~flashPhase;
            end
        end else if (state == FLASH) begin
            stateNxt = ALLRED1;
            secNxt   = durOf(ALLRED1);
            pedNxt   = 1'b0;
            tickClr  = 1'b1;
        end else if (bus.i_en && pedLatch && isGreen && (sec > SEC_W'(T_PEDMIN))) begin
            secNxt = SEC_W'(T_PEDMIN);
        end else if (tick) begin
            if (sec > SEC_W'(1)) begin
                secNxt = sec - SEC_W'(1);
            end else begin
                stateNxt = nextOf(state);
                secNxt   = durOf(nextOf(state));
                if ((stateNxt == ALLRED1) || (stateNxt == ALLRED2)) begin
                    pedNxt = 1'b0;
                end
            end
        end

        case (stateNxt)
            A_GREEN:  ledANxt = LED_GRN;
            A_YELLOW: ledANxt = LED_YEL;
            B_GREEN:  ledBNxt = LED_GRN;
            B_YELLOW: ledBNxt = LED_YEL;
            FLASH: begin
                ledANxt = phaseNxt ? LED_YEL : LED_OFF;
                ledBNxt = phaseNxt ? LED_YEL : LED_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ALLRED2;
            sec          <= SEC_W'(T_ALLRED);
            {tens, ones} <= toBcd(SEC_W'(T_ALLRED));
            pedLatch     <= 1'b0;
            flashPhase   <= 1'b0;
            ledA         <= LED_RED;
            ledB         <= LED_RED;
        end else begin
            state        <= stateNxt;
            sec          <= secNxt;
            {tens, ones} <= toBcd(secNxt);
            pedLatch     <= pedNxt;
            flashPhase   <= phaseNxt;
            ledA         <= ledANxt;
            ledB         <= ledBNxt;
        end
    end

    assign bus.o_led_a    = ledA;
    assign bus.o_led_b    = ledB;
    assign bus.o_sec      = sec;
    assign bus.o_sec_tens = tens;
    assign bus.o_sec_ones = ones;
    assign bus.o_ped_ack  = pedLatch;

endmodule
